// File: rtl/rs_encode_serial.sv
// -----------------------------------------------------------------------------
// rs_encode_serial
//   Systematic serial RS(18,16) encoder over GF(2^8). Message symbols pass
//   straight through with zero latency. Two parity symbols from the
//   generator g(x) = x^2 + 0x06*x + 0x08 (alpha = 0x02, field poly 0x11D)
//   are then appended, so that syndromes s1 and s2 of each codeword are zero.
//
// Handshake:
//   A beat moves on a port when its valid and ready are both high in the same
//   cycle. A source holds its valid and data until the beat moves.
//   in_ready mirrors out_ready while message symbols flow and is low for both
//   parity beats. Holding out_ready low freezes every register and output.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data holds a message symbol
//   in_ready   encoder accepts in_data this cycle
//   in_data    message symbol, highest-degree coefficient first
//   out_valid  out_data is valid
//   out_ready  downstream accepts out_data this cycle
//   out_data   codeword symbol
//   out_sop    first symbol of a codeword
//   out_eop    last symbol of a codeword (second parity symbol)
//   err_mask   (RS_ENC_ERR_INJECT_EN only) XORed onto every output symbol
//
// Configuration macro:
//   RS_ENC_ERR_INJECT_EN  adds err_mask. Corruption is applied only to
//                         out_data. The parity registers still use clean
//                         in_data.
// -----------------------------------------------------------------------------
module rs_encode_serial #(
  parameter int                    SYMBOL_WIDTH = 8,
  parameter int                    K            = 16,
  parameter logic [SYMBOL_WIDTH:0] PRIM_POLY    = 9'h11D
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SYMBOL_WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SYMBOL_WIDTH-1:0] out_data,
  output logic                    out_sop,
  output logic                    out_eop
`ifdef RS_ENC_ERR_INJECT_EN
  ,
  input  logic [SYMBOL_WIDTH-1:0] err_mask
`endif
);

  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);
  localparam logic [SYMBOL_WIDTH-1:0] G1 = SYMBOL_WIDTH'(8'h06);
  localparam logic [SYMBOL_WIDTH-1:0] G0 = SYMBOL_WIDTH'(8'h08);

  typedef enum logic {
    MSG = 1'b0,
    PAR = 1'b1
  } state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic                    par_idx;   // 0: first parity beat, 1: second
  logic [SYMBOL_WIDTH-1:0] r1;
  logic [SYMBOL_WIDTH-1:0] r0;

  logic [SYMBOL_WIDTH-1:0] fb;
  logic [SYMBOL_WIDTH-1:0] fb_g1;
  logic [SYMBOL_WIDTH-1:0] fb_g0;
  logic [SYMBOL_WIDTH-1:0] nominal;
  logic                    accept;
  logic                    xfer;

  // Multiply by alpha (x) with reduction by the field polynomial.
  function automatic logic [SYMBOL_WIDTH-1:0] xtime(input logic [SYMBOL_WIDTH-1:0] a);
    logic [SYMBOL_WIDTH-1:0] r;
    r = {a[SYMBOL_WIDTH-2:0], 1'b0};
    if (a[SYMBOL_WIDTH-1]) r = r ^ PRIM_POLY[SYMBOL_WIDTH-1:0];
    return r;
  endfunction

  // Shift-and-add multiply. With a constant b this reduces to an XOR network
  // with no data-dependent timing.
  function automatic logic [SYMBOL_WIDTH-1:0] gmul(input logic [SYMBOL_WIDTH-1:0] a,
                                                   input logic [SYMBOL_WIDTH-1:0] b);
    logic [SYMBOL_WIDTH-1:0] p;
    logic [SYMBOL_WIDTH-1:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < SYMBOL_WIDTH; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  assign fb     = in_data ^ r1;
  assign fb_g1  = gmul(fb, G1);
  assign fb_g0  = gmul(fb, G0);
  assign accept = in_valid && in_ready;
  assign xfer   = out_valid && out_ready;

  // Pass-through in MSG, register-driven in PAR. The parity shift register
  // moves r0 into r1 on each parity transfer, so r1 is always the symbol on
  // the wire.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    nominal   = '0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    case (state)
      MSG: begin
        in_ready  = out_ready;
        out_valid = in_valid;
        nominal   = in_data;
        // Qualified by in_valid so an idle bus shows no stray start marker.
        out_sop   = in_valid && (cnt == '0);
      end
      PAR: begin
        out_valid = 1'b1;
        nominal   = r1;
        out_eop   = par_idx;
      end
      default: ;
    endcase
  end

`ifdef RS_ENC_ERR_INJECT_EN
  assign out_data = nominal ^ err_mask;
`else
  assign out_data = nominal;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= MSG;
      cnt     <= '0;
      par_idx <= 1'b0;
      r1      <= '0;
      r0      <= '0;
    end else begin
      case (state)
        MSG: begin
          if (accept) begin
            r1 <= r0 ^ fb_g1;
            r0 <= fb_g0;
            if (cnt == CNT_LAST) begin
              cnt     <= '0;
              par_idx <= 1'b0;
              state   <= PAR;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        PAR: begin
          if (xfer) begin
            r1 <= r0;
            r0 <= '0;
            if (par_idx) begin
              par_idx <= 1'b0;
              state   <= MSG;
            end else begin
              par_idx <= 1'b1;
            end
          end
        end
        default: state <= MSG;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_encode_serial.sv
module tb_rs_encode_serial;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_sop;
  logic       out_eop;
`ifdef RS_ENC_ERR_INJECT_EN
  logic [7:0] err_mask;
`endif

  always #5 clk = ~clk;

  rs_encode_serial dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sop   (out_sop),
    .out_eop   (out_eop)
`ifdef RS_ENC_ERR_INJECT_EN
    ,
    .err_mask  (err_mask)
`endif
  );

  // ---------------- scoreboard state ----------------
  int         tests_run = 0;
  int         fails     = 0;
  logic [7:0] msg_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_d[$];
  logic       got_s[$];
  logic       got_e[$];
  logic       got_r[$];
  int         stall_bad;
  int         inj_pos = -1;
  int         last_cycles;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      y = y >> 1;
      x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
    end
    return p;
  endfunction

  // Long division of m(x)*x^2 by g(x); remainder gives the parity.
  function automatic void model_encode(input logic [7:0] m[16]);
    logic [7:0] c[18];
    for (int i = 0; i < 16; i++) c[i] = m[i];
    c[16] = 8'h00;
    c[17] = 8'h00;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] q;
      q = c[i];
      c[i + 1] = c[i + 1] ^ gf_mul(q, 8'h06);
      c[i + 2] = c[i + 2] ^ gf_mul(q, 8'h08);
    end
    for (int i = 0; i < 16; i++) exp_q.push_back(m[i]);
    exp_q.push_back(c[16]);
    exp_q.push_back(c[17]);
  endfunction

  // Evaluate codeword polynomial at alpha^j (Horner).
  function automatic logic [7:0] syndrome(input logic [7:0] c[18], input int j);
    logic [7:0] aj = (j == 1) ? 8'h02 : 8'h04;
    logic [7:0] s  = 8'h00;
    for (int i = 0; i < 18; i++) s = gf_mul(s, aj) ^ c[i];
    return s;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_sb();
    msg_q.delete(); exp_q.delete();
    got_d.delete(); got_s.delete(); got_e.delete(); got_r.delete();
    stall_bad = 0;
  endtask

  // kind 0: zeros, 1: single trailing 0x01, 2: random
  task automatic add_msg(input int kind);
    logic [7:0] m[16];
    for (int i = 0; i < 16; i++) begin
      case (kind)
        0:       m[i] = 8'h00;
        1:       m[i] = (i == 15) ? 8'h01 : 8'h00;
        default: m[i] = 8'($urandom_range(255));
      endcase
      msg_q.push_back(m[i]);
    end
    model_encode(m);
  endtask

  // Drives msg_q with random valid/ready duty and captures output beats.
  task automatic pump(input int n_beats, input int vpct, input int rpct, input int max_cyc);
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic       pin = 1'b0;
    logic [7:0] pd = 8'h00;
    int         cyc = 0;
    while (got_d.size() < n_beats && cyc < max_cyc) begin
      @(negedge clk);
      if (!(in_valid && !pin)) begin
        in_valid = (msg_q.size() > 0) && ($urandom_range(99) < vpct);
        in_data  = in_valid ? msg_q[0] : 8'($urandom_range(255));
      end
      out_ready = ($urandom_range(99) < rpct);
`ifdef RS_ENC_ERR_INJECT_EN
      err_mask = (inj_pos >= 0 && (got_d.size() % 18) == inj_pos) ? 8'h01 : 8'h00;
`endif
      #1;
      if (pv && !pr && (out_valid !== 1'b1 || out_data !== pd)) stall_bad++;
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_s.push_back(out_sop);
        got_e.push_back(out_eop);
        got_r.push_back(in_ready);
      end
      if (in_valid && in_ready) void'(msg_q.pop_front());
      pv = out_valid; pr = out_ready; pin = in_ready; pd = out_data;
      cyc++;
    end
    last_cycles = cyc;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
`ifdef RS_ENC_ERR_INJECT_EN
    err_mask = 8'h00;
`endif
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
`ifdef RS_ENC_ERR_INJECT_EN
    err_mask = 8'h00;
`endif
    repeat (3) @(negedge clk);
    #1;
    tests_run++;
    if ({out_valid, out_sop, out_eop, out_data} !== 11'h0) begin
      fails++;
      $display("FAIL reset_outputs: got v=%b s=%b e=%b d=%h want all 0", out_valid, out_sop, out_eop, out_data);
    end
    tests_run++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready_hi: got %b want 1", in_ready); end
    out_ready = 1'b0; #1;
    tests_run++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready_lo: got %b want 0", in_ready); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero();
    clear_sb(); add_msg(0);
    pump(18, 100, 100, 200);
    tests_run++;
    if (got_d.size() != 18) begin fails++; $display("FAIL zero_count: got %0d want 18", got_d.size()); end
    for (int i = 0; i < got_d.size() && i < 18; i++) begin
      tests_run++;
      if (got_d[i] !== 8'h00 || got_s[i] !== (i == 0) || got_e[i] !== (i == 17)) begin
        fails++;
        $display("FAIL zero_beat %0d: got d=%h s=%b e=%b want d=00 s=%b e=%b", i, got_d[i], got_s[i], got_e[i], i == 0, i == 17);
      end
    end
  endtask

  task automatic test_single_one();
    logic [7:0] tail[4];
    tail[0] = 8'h00; tail[1] = 8'h01; tail[2] = 8'h06; tail[3] = 8'h08;
    clear_sb(); add_msg(1);
    pump(18, 100, 100, 200);
    tests_run++;
    if (got_d.size() != 18) begin fails++; $display("FAIL one_count: got %0d want 18", got_d.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (got_d[14 + i] !== tail[i]) begin
          fails++; $display("FAIL one_tail %0d: got %h want %h", 14 + i, got_d[14 + i], tail[i]);
        end
      end
      for (int i = 0; i < 18; i++) begin
        tests_run++;
        if (got_d[i] !== exp_q[i]) begin fails++; $display("FAIL one_model %0d: got %h want %h", i, got_d[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_random_backpressure();
    logic [7:0] cw[18];
    clear_sb();
    for (int n = 0; n < 4; n++) add_msg(2);
    pump(72, 70, 60, 2000);
    tests_run++;
    if (got_d.size() != 72) begin fails++; $display("FAIL bp_count: got %0d want 72", got_d.size()); end
    else begin
      for (int i = 0; i < 72; i++) begin
        tests_run++;
        if (got_d[i] !== exp_q[i] || got_s[i] !== ((i % 18) == 0) || got_e[i] !== ((i % 18) == 17)) begin
          fails++;
          $display("FAIL bp_beat %0d: got d=%h s=%b e=%b want d=%h s=%b e=%b", i, got_d[i], got_s[i], got_e[i],
                   exp_q[i], (i % 18) == 0, (i % 18) == 17);
        end
      end
      for (int n = 0; n < 4; n++) begin
        for (int k = 0; k < 18; k++) cw[k] = got_d[n * 18 + k];
        tests_run++;
        if (syndrome(cw, 1) !== 8'h00 || syndrome(cw, 2) !== 8'h00) begin
          fails++; $display("FAIL bp_syndrome cw %0d: got s1=%h s2=%h want 00 00", n, syndrome(cw, 1), syndrome(cw, 2));
        end
      end
    end
    tests_run++;
    if (stall_bad != 0) begin fails++; $display("FAIL bp_stall_hold: got %0d violations want 0", stall_bad); end
  endtask

  task automatic test_back_to_back();
    clear_sb();
    for (int n = 0; n < 3; n++) add_msg(2);
    pump(54, 100, 100, 300);
    tests_run++;
    if (got_d.size() != 54 || last_cycles != 54) begin
      fails++; $display("FAIL b2b_count: got %0d beats in %0d cycles want 54 in 54", got_d.size(), last_cycles);
    end else begin
      for (int i = 0; i < 54; i++) begin
        tests_run++;
        if (got_d[i] !== exp_q[i] || got_r[i] !== ((i % 18) < 16)) begin
          fails++;
          $display("FAIL b2b_beat %0d: got d=%h rdy=%b want d=%h rdy=%b", i, got_d[i], got_r[i], exp_q[i], (i % 18) < 16);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_sb();
    for (int i = 0; i < 8; i++) msg_q.push_back(8'($urandom_range(255) | 1));
    pump(8, 100, 100, 100);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_sb(); add_msg(0);
    pump(18, 100, 100, 200);
    tests_run++;
    if (got_d.size() != 18) begin fails++; $display("FAIL rst_mid_count: got %0d want 18", got_d.size()); end
    for (int i = 0; i < got_d.size() && i < 18; i++) begin
      tests_run++;
      if (got_d[i] !== 8'h00 || got_s[i] !== (i == 0) || got_e[i] !== (i == 17)) begin
        fails++;
        $display("FAIL rst_mid_beat %0d: got d=%h s=%b e=%b want d=00 s=%b e=%b", i, got_d[i], got_s[i], got_e[i], i == 0, i == 17);
      end
    end
  endtask

`ifdef RS_ENC_ERR_INJECT_EN
  task automatic test_err_inject();
    logic [7:0] cw[18];
    clear_sb(); add_msg(2);
    exp_q[3] = exp_q[3] ^ 8'h01;
    inj_pos = 3;
    pump(18, 100, 80, 300);
    inj_pos = -1;
    tests_run++;
    if (got_d.size() != 18) begin fails++; $display("FAIL inj_count: got %0d want 18", got_d.size()); end
    else begin
      for (int i = 0; i < 18; i++) begin
        tests_run++;
        if (got_d[i] !== exp_q[i]) begin fails++; $display("FAIL inj_beat %0d: got %h want %h", i, got_d[i], exp_q[i]); end
        cw[i] = got_d[i];
      end
      tests_run++;
      if (syndrome(cw, 1) === 8'h00 || syndrome(cw, 2) === 8'h00) begin
        fails++; $display("FAIL inj_syndrome: got s1=%h s2=%h want both nonzero", syndrome(cw, 1), syndrome(cw, 2));
      end
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
`ifdef RS_ENC_ERR_INJECT_EN
    err_mask = 8'h00;
`endif
    test_reset();
    test_zero();
    test_single_one();
    test_random_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef RS_ENC_ERR_INJECT_EN
    test_err_inject();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
